column_l2_controller: RTL and testbench
=======================================

Name: column_l2_controller

Overview:
Parametrised successor to the column L2 controller. Arbitrates NUM_CORES core request ports round-robin onto an internal L2 SRAM window and a single upstream L3 port. L3 misses use a held valid/ready request channel and a separate response channel, with one outstanding miss. L2 hits from other cores continue to be served while a miss is in flight (hit-under-miss). Sits between the cores of one grid column and the global memory fabric.

Parameters:
NUM_CORES, 4, number of core request ports (>=2, power of two not required)
ADDR_WIDTH, 16, address width
DATA_WIDTH, 8, data width
L2_BASE_ADDR, 16'h8000, first address of L2 window
L2_DEPTH, 1024, L2 words; window = [L2_BASE_ADDR, L2_BASE_ADDR+L2_DEPTH-1]

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_req_valid  in  NUM_CORES  per-core request; held until core_req_ready pulse
core_req_write  in  NUM_CORES  1=write, 0=read
core_req_addr  in  NUM_CORES*ADDR_WIDTH  packed, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
core_req_data  in  NUM_CORES*DATA_WIDTH  packed write data
core_req_ready  out  NUM_CORES  one-cycle completion pulse per core
core_req_rdata  out  NUM_CORES*DATA_WIDTH  read data, valid with ready pulse
global_req_valid  out  1  L3 request valid, held until accepted
global_req_ready  in  1  L3 accepts when valid&ready
global_req_write  out  1  L3 write
global_req_addr  out  ADDR_WIDTH  L3 address
global_req_data  out  DATA_WIDTH  L3 write data
global_rsp_valid  in  1  L3 completion (reads and writes), one cycle
global_rsp_rdata  in  DATA_WIDTH  L3 read data

Behaviour:
- Reset: core_req_ready=0, core_req_rdata=0, global_req_valid=0, global_req_write=0, global_req_addr=0, global_req_data=0, rr_ptr=0, miss FSM=IDLE. L2 SRAM contents are not cleared.
- Hit decode: in_l2 = addr>=L2_BASE_ADDR && (addr-L2_BASE_ADDR)<L2_DEPTH. Compute at ADDR_WIDTH+1 bits so the window end never wraps. Offset = addr-L2_BASE_ADDR, truncated to clog2(L2_DEPTH).
- Eligible core: valid=1, no ready pulse this cycle or last cycle (prevents double service of a held request), and not the core owning the in-flight miss.
- Arbitration: each cycle, pick the first eligible core scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
- Winner is an L2 hit: SRAM access this cycle. core_req_ready[w] pulses the next cycle. Read data is registered with the pulse; a write updates SRAM at this edge. rr_ptr <= (w+1) mod NUM_CORES.
- Winner is a miss with FSM=IDLE: latch write/addr/data into the global_req_* registers and the owner id. global_req_valid=1 the next cycle. FSM->REQ. rr_ptr <= (w+1) mod NUM_CORES.
- Winner is a miss with FSM busy: not served. The scan continues to the next eligible core that is an L2 hit. rr_ptr does not advance past the unserved core.
- Miss FSM:
  - IDLE: as above.
  - REQ: hold valid and all fields stable until global_req_ready=1. Then valid drops the next cycle and FSM->WAIT.
  - WAIT: on global_rsp_valid, pulse core_req_ready[owner] the next cycle with rdata=global_rsp_rdata for reads (rdata unchanged for writes). FSM->IDLE.
- Earliest miss latency: request cycle 0, global valid cycle 1, ready cycle 1, rsp cycle 2, core ready cycle 3.
- A global_rsp_valid arriving in IDLE or REQ is ignored.
- Simultaneous L2 completion for core a and L3 completion for core b in the same cycle: both ready bits pulse. At most one L2 and one L3 completion per cycle.
- Reset mid-miss aborts it: global_req_valid drops the cycle after reset. The late response is ignored. The core must re-request.
- core_req_rdata[i] holds its last value between pulses.

Optional Feature:
VMC_PERF_CNT_EN: defined -> adds outputs perf_hits, perf_misses, perf_stalls (32 bits each).
- perf_hits and perf_misses increment per served hit and per issued miss.
- perf_stalls increments per cycle where a miss-eligible core is blocked by a busy FSM.
- All three saturate at 2^32-1 and clear on reset.
Undefined -> no counters and no ports; behaviour is otherwise identical.

Test Plan:
- Core0 writes 0xA5 to 0x8010, then reads 0x8010 -> ready pulse 1 cycle after each grant; read rdata[0]=0xA5.
- All 4 cores request L2 reads in the same cycle, rr_ptr=0 -> served in order 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
- Core1 reads 0x9000, with global_req_ready low for 3 cycles then rsp 0x3C -> addr stable 0x9000 while held; rdata[1]=0x3C; exactly one ready pulse.
- During core1's miss, core2 reads 0x8001 and core3 reads 0xA000 -> core2 served immediately; core3 issued to L3 only after core1 completes.
- Boundary: 0x83FF hits L2, 0x8400 and 0x7FFF go to L3. With ADDR_WIDTH=16, L2_BASE_ADDR=0xFC00, L2_DEPTH=1024: 0xFFFF hits L2, no wrap.
- Reset asserted in WAIT, then a global_rsp_valid arrives -> no core_req_ready pulse; FSM IDLE; a new miss issues normally.

Source files
------------

// File: rtl/column_l2_controller.sv
// rtl/column_l2_controller.sv - round-robin column L2 controller with one outstanding L3 miss and hit-under-miss
// Optional macro VMC_PERF_CNT_EN adds saturating perf_hits/perf_misses/perf_stalls outputs.
module column_l2_controller #(
    parameter int          NUM_CORES    = 4,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          DATA_WIDTH   = 8,
    parameter int unsigned L2_BASE_ADDR = 32'h8000,
    parameter int          L2_DEPTH     = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            core_req_valid,
    input  logic [NUM_CORES-1:0]            core_req_write,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] core_req_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_req_data,
    output logic [NUM_CORES-1:0]            core_req_ready,
    output logic [NUM_CORES*DATA_WIDTH-1:0] core_req_rdata,
    output logic                            global_req_valid,
    input  logic                            global_req_ready,
    output logic                            global_req_write,
    output logic [ADDR_WIDTH-1:0]           global_req_addr,
    output logic [DATA_WIDTH-1:0]           global_req_data,
    input  logic                            global_rsp_valid,
    input  logic [DATA_WIDTH-1:0]           global_rsp_rdata
`ifdef VMC_PERF_CNT_EN
    ,
    output logic [31:0]                     perf_hits,
    output logic [31:0]                     perf_misses,
    output logic [31:0]                     perf_stalls
`endif
);
    localparam int OFF_W = (L2_DEPTH > 1) ? $clog2(L2_DEPTH) : 1;
    localparam int PTR_W = $clog2(NUM_CORES);
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0] BASE_X  = AW1'(L2_BASE_ADDR);
    localparam logic [AW1-1:0] DEPTH_X = AW1'(L2_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      owner_q, owner_d;
    logic [NUM_CORES-1:0]  ready_q, ready_d, ready_prev_q;
    logic [DATA_WIDTH-1:0] rdata_q [NUM_CORES];
    logic [DATA_WIDTH-1:0] rdata_d [NUM_CORES];
    logic                  gvalid_q, gvalid_d, gwrite_q, gwrite_d;
    logic [ADDR_WIDTH-1:0] gaddr_q, gaddr_d;
    logic [DATA_WIDTH-1:0] gdata_q, gdata_d;

    logic [DATA_WIDTH-1:0] mem_q [L2_DEPTH];
    logic                  mem_we;
    logic [OFF_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic [NUM_CORES-1:0]  hit, elig;
    logic [OFF_W-1:0]      off [NUM_CORES];
    logic                  hit_found, miss_found, blocked_found;
    logic [PTR_W-1:0]      hit_idx, miss_idx, blocked_idx;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == NUM_CORES - 1) ? '0 : p + 1'b1;
    endfunction

    // Window check is done one bit wider than the address so the last window word never wraps.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            hit[i]  = ({1'b0, core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} >= BASE_X) &&
                      (({1'b0, core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]} - BASE_X) < DEPTH_X);
            off[i]  = OFF_W'(core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] - ADDR_WIDTH'(L2_BASE_ADDR));
            elig[i] = core_req_valid[i] & ~ready_q[i] & ~ready_prev_q[i] &
                      ~((state_q != S_IDLE) && (owner_q == PTR_W'(i)));
        end
    end

    always_comb begin
        int j;
        j             = 0;
        hit_found     = 1'b0;
        miss_found    = 1'b0;
        blocked_found = 1'b0;
        hit_idx       = '0;
        miss_idx      = '0;
        blocked_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NUM_CORES) j = j - NUM_CORES;
            if (elig[j] && !hit_found && !miss_found) begin
                if (hit[j]) begin
                    hit_found = 1'b1;
                    hit_idx   = PTR_W'(j);
                end else if (state_q == S_IDLE) begin
                    miss_found = 1'b1;
                    miss_idx   = PTR_W'(j);
                end else if (!blocked_found) begin
                    blocked_found = 1'b1;
                    blocked_idx   = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        ready_d   = '0;
        rdata_d   = rdata_q;
        gvalid_d  = gvalid_q;
        gwrite_d  = gwrite_q;
        gaddr_d   = gaddr_q;
        gdata_d   = gdata_q;
        mem_we    = 1'b0;
        mem_waddr = off[hit_idx];
        mem_wdata = core_req_data[hit_idx*DATA_WIDTH +: DATA_WIDTH];
        if (hit_found) begin
            ready_d[hit_idx] = 1'b1;
            if (core_req_write[hit_idx]) mem_we = 1'b1;
            else rdata_d[hit_idx] = mem_q[off[hit_idx]];
            // A skipped miss keeps its priority so it is first in line once the L3 port frees up.
            rr_ptr_d = blocked_found ? blocked_idx : next_ptr(hit_idx);
        end
        case (state_q)
            S_IDLE: if (miss_found) begin
                gvalid_d = 1'b1;
                gwrite_d = core_req_write[miss_idx];
                gaddr_d  = core_req_addr[miss_idx*ADDR_WIDTH +: ADDR_WIDTH];
                gdata_d  = core_req_data[miss_idx*DATA_WIDTH +: DATA_WIDTH];
                owner_d  = miss_idx;
                rr_ptr_d = next_ptr(miss_idx);
                state_d  = S_REQ;
            end
            S_REQ: if (global_req_ready) begin
                gvalid_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: if (global_rsp_valid) begin
                ready_d[owner_q] = 1'b1;
                if (!gwrite_q) rdata_d[owner_q] = global_rsp_rdata;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            ready_q      <= '0;
            ready_prev_q <= '0;
            for (int i = 0; i < NUM_CORES; i++) rdata_q[i] <= '0;
            gvalid_q     <= 1'b0;
            gwrite_q     <= 1'b0;
            gaddr_q      <= '0;
            gdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            ready_q      <= ready_d;
            ready_prev_q <= ready_q;
            rdata_q      <= rdata_d;
            gvalid_q     <= gvalid_d;
            gwrite_q     <= gwrite_d;
            gaddr_q      <= gaddr_d;
            gdata_q      <= gdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    genvar g;
    for (g = 0; g < NUM_CORES; g++) begin : g_rdata
        assign core_req_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rdata_q[g];
    end

    assign core_req_ready   = ready_q;
    assign global_req_valid = gvalid_q;
    assign global_req_write = gwrite_q;
    assign global_req_addr  = gaddr_q;
    assign global_req_data  = gdata_q;

`ifdef VMC_PERF_CNT_EN
    logic [31:0] hits_q, misses_q, stalls_q;
    logic        stall;
    assign stall = (state_q != S_IDLE) && |(elig & ~hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
            stalls_q <= '0;
        end else begin
            if (hit_found && hits_q != '1)    hits_q   <= hits_q + 32'd1;
            if (miss_found && misses_q != '1) misses_q <= misses_q + 32'd1;
            if (stall && stalls_q != '1)      stalls_q <= stalls_q + 32'd1;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
    assign perf_stalls = stalls_q;
`endif
endmodule

// File: tb/tb_column_l2_controller.sv
// tb/tb_column_l2_controller.sv - scoreboard bench for column_l2_controller
module tb_column_l2_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  valid, wr, ready;
    logic [63:0] addr;
    logic [31:0] wdata, rdata;
    logic        gvalid, gready, gwrite, rspv;
    logic [15:0] gaddr;
    logic [7:0]  gdata, rsprd;

    logic [3:0]  hvalid, hwr, hready;
    logic [63:0] haddr;
    logic [31:0] hdata, hrdata;
    logic        hgvalid, hgwrite;
    logic        hgready = 1'b0;
    logic        hrspv   = 1'b0;
    logic [7:0]  hrsprd  = 8'h00;
    logic [15:0] hgaddr;
    logic [7:0]  hgdata;

    column_l2_controller dut (
        .clk(clk), .reset(reset),
        .core_req_valid(valid), .core_req_write(wr), .core_req_addr(addr), .core_req_data(wdata),
        .core_req_ready(ready), .core_req_rdata(rdata),
        .global_req_valid(gvalid), .global_req_ready(gready), .global_req_write(gwrite),
        .global_req_addr(gaddr), .global_req_data(gdata),
        .global_rsp_valid(rspv), .global_rsp_rdata(rsprd)
    );

    column_l2_controller #(.L2_BASE_ADDR(32'hFC00)) dut_hi (
        .clk(clk), .reset(reset),
        .core_req_valid(hvalid), .core_req_write(hwr), .core_req_addr(haddr), .core_req_data(hdata),
        .core_req_ready(hready), .core_req_rdata(hrdata),
        .global_req_valid(hgvalid), .global_req_ready(hgready), .global_req_write(hgwrite),
        .global_req_addr(hgaddr), .global_req_data(hgdata),
        .global_rsp_valid(hrspv), .global_rsp_rdata(hrsprd)
    );

    typedef struct { int core; logic [7:0] rdata; int t0; } exp_t;
    typedef struct { int core; int lat; int at; } log_t;
    exp_t       sb[$];
    log_t       lg[$];
    logic [7:0] last_m [4];
    int         pulses [4];
    int         checks = 0;
    int         passes = 0;
    int         cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Every ready pulse must retire the oldest outstanding expectation for that core.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                if (ready[i]) begin
                    int idx;
                    idx = -1;
                    foreach (sb[j]) if (idx < 0 && sb[j].core == i) idx = j;
                    checks++;
                    if (idx < 0) begin
                        $display("FAIL sb_unexpected core %0d pulsed at cycle %0d, required no pulse", i, cyc);
                    end else begin
                        if (rdata[i*8 +: 8] !== sb[idx].rdata)
                            $display("FAIL sb_rdata core %0d got %h required %h", i, rdata[i*8 +: 8], sb[idx].rdata);
                        else passes++;
                        lg.push_back('{i, cyc - sb[idx].t0, cyc});
                        sb.delete(idx);
                    end
                    valid[i] = 1'b0;
                    pulses[i]++;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int c, input bit w, input logic [15:0] a, input logic [7:0] d, input logic [7:0] rd_exp);
        exp_t e;
        e.core  = c;
        e.rdata = w ? last_m[c] : rd_exp;
        e.t0    = cyc;
        last_m[c] = e.rdata;
        sb.push_back(e);
        valid[c] = 1'b1;
        wr[c]    = w;
        addr[c*16 +: 16] = a;
        wdata[c*8 +: 8]  = d;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL %s_timeout outstanding %0d required 0", nm, sb.size());
            sb.delete();
            valid = '0;
        end else passes++;
        repeat (2) tick();
    endtask

    task automatic l3_serve(input int hold, input logic [15:0] ea, input bit ew, input logic [7:0] ed,
                            input logic [7:0] rsp, input string nm);
        int n;
        n = 0;
        while (gvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (gvalid !== 1'b1) begin
            $display("FAIL %s_gvalid got %b required 1", nm, gvalid);
            return;
        end
        passes++;
        checks++;
        if (gaddr !== ea || gwrite !== ew || (ew && gdata !== ed))
            $display("FAIL %s_fields got addr %h write %b data %h required %h %b %h", nm, gaddr, gwrite, gdata, ea, ew, ed);
        else passes++;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (gvalid !== 1'b1 || gaddr !== ea)
                $display("FAIL %s_hold got valid %b addr %h required 1 %h", nm, gvalid, gaddr, ea);
            else passes++;
        end
        tick();
        gready = 1'b1;
        tick();
        gready = 1'b0;
        @(negedge clk);
        checks++;
        if (gvalid !== 1'b0) $display("FAIL %s_drop got valid %b required 0", nm, gvalid);
        else passes++;
        tick();
        rspv  = 1'b1;
        rsprd = rsp;
        tick();
        rspv  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = '0; wr = '0; addr = '0; wdata = '0; gready = 1'b0; rspv = 1'b0; rsprd = '0;
        hvalid = '0; hwr = '0; haddr = '0; hdata = '0;
        for (int i = 0; i < 4; i++) begin last_m[i] = 8'h00; pulses[i] = 0; end
        repeat (3) tick();
        @(negedge clk);
        checks++; if (ready !== 4'b0) $display("FAIL rst_ready got %b required 0", ready); else passes++;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h required 0", rdata); else passes++;
        checks++; if (gvalid !== 1'b0 || gwrite !== 1'b0) $display("FAIL rst_gvalid got %b %b required 0 0", gvalid, gwrite); else passes++;
        checks++; if (gaddr !== 16'h0 || gdata !== 8'h0) $display("FAIL rst_gfields got %h %h required 0 0", gaddr, gdata); else passes++;
        checks++; if (hready !== 4'b0 || hgvalid !== 1'b0) $display("FAIL rst_hi got %b %b required 0 0", hready, hgvalid); else passes++;
        tick();
        reset = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_l2_write_read();
        req(0, 1, 16'h8010, 8'hA5, 8'h00);
        wait_idle("wr_8010");
        checks++; if (lg[$].core !== 0 || lg[$].lat !== 1) $display("FAIL wr_lat got core %0d lat %0d required 0 1", lg[$].core, lg[$].lat); else passes++;
        req(0, 0, 16'h8010, 8'h00, 8'hA5);
        wait_idle("rd_8010");
        checks++; if (lg[$].lat !== 1) $display("FAIL rd_lat got %0d required 1", lg[$].lat); else passes++;
        checks++; if (rdata[7:0] !== 8'hA5 || gvalid !== 1'b0) $display("FAIL rd_hold got %h gvalid %b required a5 0", rdata[7:0], gvalid); else passes++;
    endtask

    task automatic test_rr_order();
        int base;
        for (int i = 0; i < 4; i++) begin
            req(i, 1, 16'h8020 + 16'(i), 8'h10 + 8'(i), 8'h00);
            wait_idle("rr_fill");
        end
        base = lg.size();
        for (int i = 0; i < 4; i++) req(i, 0, 16'h8020 + 16'(i), 8'h00, 8'h10 + 8'(i));
        wait_idle("rr_reads");
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lg[base+k].core !== k || lg[base+k].at !== lg[base].at + k || lg[base].lat !== 1)
                $display("FAIL rr_order slot %0d got core %0d at %0d required core %0d at %0d", k, lg[base+k].core, lg[base+k].at, k, lg[base].at + k);
            else passes++;
        end
        base = lg.size();
        req(2, 0, 16'h8022, 8'h00, 8'h12);
        req(0, 0, 16'h8020, 8'h00, 8'h10);
        wait_idle("rr_wrap");
        checks++;
        if (lg[base].core !== 0 || lg[base+1].core !== 2)
            $display("FAIL rr_ptr_zero got order %0d,%0d required 0,2", lg[base].core, lg[base+1].core);
        else passes++;
    endtask

    task automatic test_miss_hold();
        int p0;
        p0 = pulses[1];
        req(1, 0, 16'h9000, 8'h00, 8'h3C);
        l3_serve(3, 16'h9000, 1'b0, 8'h00, 8'h3C, "miss_hold");
        wait_idle("miss_hold");
        repeat (3) tick();
        checks++;
        if (pulses[1] - p0 !== 1 || rdata[15:8] !== 8'h3C)
            $display("FAIL miss_pulses got %0d rdata %h required 1 3c", pulses[1] - p0, rdata[15:8]);
        else passes++;
    endtask

    task automatic test_hit_under_miss();
        int base;
        req(2, 1, 16'h8001, 8'h66, 8'h00);
        wait_idle("hum_fill");
        base = lg.size();
        req(1, 0, 16'h9000, 8'h00, 8'h5A);
        repeat (2) tick();
        req(2, 0, 16'h8001, 8'h00, 8'h66);
        req(3, 0, 16'hA000, 8'h00, 8'h77);
        repeat (4) tick();
        checks++;
        if (lg.size() !== base + 1 || gaddr !== 16'h9000 || gvalid !== 1'b1)
            $display("FAIL hum_hit got done %0d gaddr %h gvalid %b required 1 9000 1", lg.size() - base, gaddr, gvalid);
        else passes++;
        l3_serve(0, 16'h9000, 1'b0, 8'h00, 8'h5A, "hum_c1");
        l3_serve(0, 16'hA000, 1'b0, 8'h00, 8'h77, "hum_c3");
        wait_idle("hum");
        checks++;
        if (lg.size() !== base + 3 || lg[base].core !== 2 || lg[base+1].core !== 1 || lg[base+2].core !== 3)
            $display("FAIL hum_order got %0d entries required order 2,1,3", lg.size() - base);
        else passes++;
    endtask

    task automatic test_boundary();
        req(0, 1, 16'h83FF, 8'h3E, 8'h00);
        wait_idle("b83ff_w");
        req(0, 0, 16'h83FF, 8'h00, 8'h3E);
        wait_idle("b83ff_r");
        checks++; if (lg[$].lat !== 1 || gvalid !== 1'b0) $display("FAIL b83ff_hit got lat %0d gvalid %b required 1 0", lg[$].lat, gvalid); else passes++;
        req(1, 0, 16'h8400, 8'h00, 8'h11);
        l3_serve(0, 16'h8400, 1'b0, 8'h00, 8'h11, "b8400");
        wait_idle("b8400");
        req(2, 1, 16'h7FFF, 8'hC3, 8'h00);
        l3_serve(0, 16'h7FFF, 1'b1, 8'hC3, 8'hEE, "b7fff");
        wait_idle("b7fff");
        hvalid[0] = 1'b1; hwr[0] = 1'b1; haddr[15:0] = 16'hFFFF; hdata[7:0] = 8'h99;
        @(negedge clk); @(negedge clk);
        checks++; if (hready[0] !== 1'b1 || hgvalid !== 1'b0) $display("FAIL hi_ffff_w got ready %b gvalid %b required 1 0", hready[0], hgvalid); else passes++;
        hvalid[0] = 1'b0;
        repeat (3) tick();
        hvalid[0] = 1'b1; hwr[0] = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++; if (hready[0] !== 1'b1 || hrdata[7:0] !== 8'h99) $display("FAIL hi_ffff_r got ready %b data %h required 1 99", hready[0], hrdata[7:0]); else passes++;
        hvalid[0] = 1'b0;
        repeat (3) tick();
        hvalid[0] = 1'b1; haddr[15:0] = 16'hFBFF;
        @(negedge clk); @(negedge clk);
        checks++; if (hgvalid !== 1'b1 || hgaddr !== 16'hFBFF || hready[0] !== 1'b0) $display("FAIL hi_fbff got gvalid %b addr %h ready %b required 1 fbff 0", hgvalid, hgaddr, hready[0]); else passes++;
        hvalid[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_miss();
        req(0, 0, 16'h9100, 8'h00, 8'h00);
        repeat (2) tick();
        gready = 1'b1;
        tick();
        gready = 1'b0;
        sb.delete();
        valid = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (gvalid !== 1'b0) $display("FAIL rmid_drop got %b required 0", gvalid); else passes++;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) last_m[i] = 8'h00;
        tick();
        rspv = 1'b1; rsprd = 8'h99;
        tick();
        rspv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (ready !== 4'b0 || gvalid !== 1'b0) $display("FAIL rmid_quiet got ready %b gvalid %b required 0 0", ready, gvalid); else passes++;
        end
        tick();
        req(0, 0, 16'h9200, 8'h00, 8'h42);
        l3_serve(0, 16'h9200, 1'b0, 8'h00, 8'h42, "rmid_new");
        wait_idle("rmid_new");
    endtask

    initial begin
        test_reset();
        test_l2_write_read();
        test_rr_order();
        test_miss_hold();
        test_hit_under_miss();
        test_boundary();
        test_reset_mid_miss();
        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
